// File: rtl/skinny_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : skinny_round_ctrl_if
// Purpose  : Handshake and control bundle between the SKINNY round sequencer
//            and its surroundings (block source, round datapath, constant LUT,
//            result sink).
// Signals  : start      - request to process one block
//            ready      - sequencer idle, able to accept start
//            load       - core latches plaintext/tweakey on this edge
//            round_en   - core advances by RNDS_PER_CLK rounds on this edge
//            cnt[5:0]   - round-group index into the constant LUT
//            last       - final round group of the block
//            out_valid  - core state holds the finished ciphertext
//            out_ready  - downstream accepts the result
// Modports : master - block source / result sink side
//            slave  - sequencer side
// Revision : 1.0 - initial release
// ============================================================================
interface skinny_round_ctrl_if;
    logic       start;
    logic       ready;
    logic       load;
    logic       round_en;
    logic [5:0] cnt;
    logic       last;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output start,
        output out_ready,
        input  ready,
        input  load,
        input  round_en,
        input  cnt,
        input  last,
        input  out_valid
    );

    modport slave (
        input  start,
        input  out_ready,
        output ready,
        output load,
        output round_en,
        output cnt,
        output last,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/skinny_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : skinny_round_ctrl
// Purpose  : Round sequencer for the unrolled SKINNY-128-384+ datapath
//            (40 rounds per block). Accepts a block, steps the round-group
//            counter that addresses the round-constant LUT, then holds the
//            finished block until downstream takes it.
// Params   : RNDS_PER_CLK - rounds executed per clock (divisor of 40)
// Ports    : clk  - clock, rising edge
//            rst  - synchronous reset, active-high
//            bus  - skinny_round_ctrl_if.slave (start/ready/load, round_en,
//                   cnt, last, out_valid/out_ready)
// Revision : 1.0 - initial release
// ============================================================================
module skinny_round_ctrl #(
    parameter int RNDS_PER_CLK = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    skinny_round_ctrl_if.slave bus
);

    localparam int TOTAL_RNDS = 40;

    localparam bit RNDS_LEGAL = (RNDS_PER_CLK == 1)  || (RNDS_PER_CLK == 2)  ||
                                (RNDS_PER_CLK == 4)  || (RNDS_PER_CLK == 5)  ||
                                (RNDS_PER_CLK == 8)  || (RNDS_PER_CLK == 10) ||
                                (RNDS_PER_CLK == 20) || (RNDS_PER_CLK == 40);

    // Guarded so an illegal value reports the elaboration error below instead
    // of a divide-by-zero.
    localparam int         CNT_MAX_INT = RNDS_LEGAL ? (TOTAL_RNDS / RNDS_PER_CLK - 1) : 0;
    localparam logic [5:0] CNT_MAX     = 6'(CNT_MAX_INT);

    generate
        if (!RNDS_LEGAL) begin : g_bad_rnds_per_clk
            $error("skinny_round_ctrl: RNDS_PER_CLK must divide 40 (1,2,4,5,8,10,20,40)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] round_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_cnt <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        round_cnt <= 6'd0;
                    end
                end
                RUN: begin
                    // The counter stops at CNT_MAX so the LUT index stays
                    // stable while the result waits in DONE.
                    if (round_cnt == CNT_MAX) begin
                        state <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        round_cnt <= 6'd0;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean idle state.
                    state     <= IDLE;
                    round_cnt <= 6'd0;
                end
            endcase
        end
    end

    // Outputs decode purely from registers, except load which must see start
    // in the same cycle so the core captures the block on the accepting edge.
    assign bus.ready     = (state == IDLE);
    assign bus.load      = bus.start & (state == IDLE);
    assign bus.round_en  = (state == RUN);
    assign bus.cnt       = round_cnt;
    assign bus.last      = (state == RUN) && (round_cnt == CNT_MAX);
    assign bus.out_valid = (state == DONE);

endmodule
`default_nettype wire
